// File: rtl/qmult_seq.sv
// ---------------------------------------------------------------------------
// qmult_seq -- sequential shift-add fixed-point multiplier, sign-magnitude Q,N
//
// Multiplies two sign-magnitude Q-format words. It processes one multiplier
// bit per clock. It uses the same start/complete/overflow handshake as the
// sequential divider, so either unit can drive the same iteration logic.
//
// Ports
//   i_clk           rising-edge clock
//   i_rst_n         asynchronous active-low reset
//   i_multiplicand  operand A, sign-magnitude Q format (N bits)
//   i_multiplier    operand B, sign-magnitude Q format (N bits)
//   i_start         request a multiply; sampled only while o_complete=1
//   o_result_out    product, sign-magnitude Q format; held until the next
//                   accepted operation completes
//   o_complete      1 = idle with a valid result, 0 = busy
//   o_overflow      1 = the scaled product magnitude did not fit in N-1 bits
// ---------------------------------------------------------------------------
module qmult_seq #(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_multiplicand,
  input  logic [N-1:0] i_multiplier,
  input  logic         i_start,
  output logic [N-1:0] o_result_out,
  output logic         o_complete,
  output logic         o_overflow
);

  // Full-precision magnitude product width: (N-1) x (N-1) bits.
  localparam int AW = 2*N - 2;
  localparam int CW = $clog2(N);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   acc_q,   acc_d;
  logic [AW-1:0]   a_q,     a_d;
  logic [N-2:0]    b_q,     b_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic            sign_q,  sign_d;
  logic [N-1:0]    res_q,   res_d;
  logic            ovf_q,   ovf_d;

  logic [AW-1:0]   acc_sum;

  // Drop the Q fraction bits of the product, with truncation and no rounding.
  function automatic logic [N-2:0] scale_trunc(input logic [AW-1:0] p);
    return p[N-2+Q:Q];
  endfunction

  // Detect any product bit that lies above the representable magnitude.
  function automatic logic mag_ovf(input logic [AW-1:0] p);
    return |p[AW-1:N-1+Q];
  endfunction

  // Partial-product add for the current multiplier bit (pre-edge A and B).
  assign acc_sum = acc_q + (b_q[0] ? a_q : '0);

  // --- next-state / datapath ---
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    res_d   = res_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = BUSY;
          a_d     = {{(AW-(N-1)){1'b0}}, i_multiplicand[N-2:0]};
          b_d     = i_multiplier[N-2:0];
          sign_d  = i_multiplicand[N-1] ^ i_multiplier[N-1];
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = CW'(N-2);
        end
      end
      BUSY: begin
        acc_d = acc_sum;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        if (cnt_q == '0) begin
          // The last multiplier bit is consumed on this edge. Publish the
          // product, including this edge's add.
          state_d = IDLE;
          cnt_d   = '0;
          res_d   = {sign_q, scale_trunc(acc_sum)};
          ovf_d   = mag_ovf(acc_sum);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // --- state registers ---
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_complete   = (state_q == IDLE);
  assign o_result_out = res_q;
  assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_qmult_seq.sv
// ---------------------------------------------------------------------------
// tb_qmult_seq -- directed self-checking bench for qmult_seq (Q=15, N=32).
// ---------------------------------------------------------------------------
module tb_qmult_seq;

  logic        clk;
  logic        rst_n;
  logic [31:0] mc;
  logic [31:0] mr;
  logic        st;
  logic [31:0] res;
  logic        cmpl;
  logic        ovf;

  int ncmp = 0;
  int nerr = 0;

  qmult_seq #(.Q(15), .N(32)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_multiplicand (mc),
    .i_multiplier   (mr),
    .i_start        (st),
    .o_result_out   (res),
    .o_complete     (cmpl),
    .o_overflow     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for completion starting at the negedge just after the
  // start edge; returns the number of clock edges until o_complete is seen.
  // If inj > 0, a one-cycle i_start pulse is raised after edge inj.
  task automatic wait_done(input int inj, output int cyc);
    cyc = 0;
    while (!cmpl && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (inj > 0) st = (cyc == inj);
    end
    if (inj > 0) st = 1'b0;
  endtask

  // One full operation: start, scramble the operand inputs, wait, check.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input int inj, input logic [31:0] er, input logic eo);
    int cyc;
    @(negedge clk);
    mc = a; mr = b; st = 1'b1;
    @(negedge clk);
    st = 1'b0;
    mc = 32'h7FFF8000;
    mr = 32'h7FFFFFFF;
    chk({tag, "_busy"}, {31'd0, cmpl}, 32'd0);
    wait_done(inj, cyc);
    chk({tag, "_lat"}, 32'(cyc), 32'd31);
    chk({tag, "_res"}, res, er);
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0;
    mc = '0; mr = '0; st = 1'b0;
    #1;
    chk("rst_cmpl", {31'd0, cmpl}, 32'd1);
    chk("rst_res",  res, 32'd0);
    chk("rst_ovf",  {31'd0, ovf}, 32'd0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // Basic sign/magnitude cases
    do_op("p15x2",   32'h0000C000, 32'h00010000, 0, 32'h00018000, 1'b0);
    do_op("n15x2",   32'h8000C000, 32'h00010000, 0, 32'h80018000, 1'b0);
    do_op("nn15x2",  32'h8000C000, 32'h80010000, 0, 32'h00018000, 1'b0);
    // Overflow: 65535.0 x 2.0
    do_op("ovf",     32'h7FFF8000, 32'h00010000, 0, 32'h7FFF0000, 1'b1);
    // Truncation of fraction bits, sign kept on a zero magnitude
    do_op("tiny",    32'h00000001, 32'h00004000, 0, 32'h00000000, 1'b0);
    do_op("tinyneg", 32'h80000001, 32'h00004000, 0, 32'h80000000, 1'b0);
    // A start pulse while busy must be ignored
    do_op("inject",  32'h0000C000, 32'h00010000, 10, 32'h00018000, 1'b0);

    // i_start held high: second op is accepted one cycle after completion
    @(negedge clk);
    mc = 32'h0000C000; mr = 32'h00010000; st = 1'b1;
    @(negedge clk);
    wait_done(0, cyc);
    chk("hold1_lat", 32'(cyc), 32'd31);
    chk("hold1_res", res, 32'h00018000);
    mc = 32'h8000C000; mr = 32'h00010000;
    @(negedge clk);
    chk("hold_idle1", {31'd0, cmpl}, 32'd0);
    st = 1'b0;
    wait_done(0, cyc);
    chk("hold2_lat", 32'(cyc), 32'd31);
    chk("hold2_res", res, 32'h80018000);

    // Asynchronous reset in the middle of an operation
    @(negedge clk);
    mc = 32'h0000C000; mr = 32'h00010000; st = 1'b1;
    @(negedge clk);
    st = 1'b0;
    repeat (15) @(negedge clk);
    chk("pre_rst_busy", {31'd0, cmpl}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_cmpl", {31'd0, cmpl}, 32'd1);
    chk("arst_res",  res, 32'd0);
    chk("arst_ovf",  {31'd0, ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("fresh",   32'h0000C000, 32'h00010000, 0, 32'h00018000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
